// File: rtl/ekf_pkg.sv
// Shared EKF command-path definitions: stage codes, fixed-point format and sequencer states.
package ekf_pkg;
    localparam int DATA_INT_BIT = 12;
    localparam int DATA_DEC_BIT = 19;

    localparam logic [2:0] STAGE_IDLE  = 3'b000;
    localparam logic [2:0] STAGE_PRD   = 3'b001;
    localparam logic [2:0] STAGE_NEW   = 3'b010;
    localparam logic [2:0] STAGE_UPD   = 3'b011;
    localparam logic [2:0] STAGE_ASSOC = 3'b100;

    typedef enum logic [2:0] {
        STG_IDLE  = 3'b000,
        STG_PRD   = 3'b001,
        STG_NEW   = 3'b010,
        STG_UPD   = 3'b011,
        STG_ASSOC = 3'b100
    } stage_e;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_PRD_ISSUE,
        SEQ_PRD_WAIT,
        SEQ_CHECK,
        SEQ_FEAT_ISSUE,
        SEQ_FEAT_WAIT
    } seq_state_e;
endpackage

// File: rtl/ekf_feat_buf.sv
// Single-frame observation buffer: MAX_FEAT (rk, phi) pairs, frame time, completion flag
// and sticky overflow. A release empties the frame and takes priority over a same-cycle write.
module ekf_feat_buf
    import ekf_pkg::*;
#(
    parameter int DW       = 32,
    parameter int TW       = 32,
    parameter int MAX_FEAT = 20,
    localparam int CW      = $clog2(MAX_FEAT + 1),
    localparam int IW      = (MAX_FEAT > 1) ? $clog2(MAX_FEAT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_val,
    input  logic [DW-1:0] wr_rk,
    input  logic [DW-1:0] wr_phi,
    input  logic          wr_last,
    input  logic [TW-1:0] wr_time,
    output logic          wr_rdy,
    input  logic          rel,
    input  logic [CW-1:0] rd_idx,
    output logic [DW-1:0] rd_rk,
    output logic [DW-1:0] rd_phi,
    output logic          frame_done,
    output logic [CW-1:0] feat_cnt,
    output logic [TW-1:0] frame_time,
    output logic          ovf
);
    logic [DW-1:0] rk_mem  [MAX_FEAT];
    logic [DW-1:0] phi_mem [MAX_FEAT];

    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] feat_cnt_q, feat_cnt_d;
    logic          frame_done_q, frame_done_d;
    logic          ovf_q, ovf_d;
    logic [TW-1:0] frame_time_q, frame_time_d;
    logic          wr_fire;
    logic          room;

    assign wr_rdy  = !frame_done_q && !rel;
    assign wr_fire = wr_val && wr_rdy;
    assign room    = (wr_cnt_q < CW'(MAX_FEAT));

    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        feat_cnt_d   = feat_cnt_q;
        frame_done_d = frame_done_q;
        ovf_d        = ovf_q;
        frame_time_d = frame_time_q;
        if (rel) begin
            frame_done_d = 1'b0;
            wr_cnt_d     = '0;
        end else if (wr_fire) begin
            if (wr_cnt_q == '0) begin
                frame_time_d = wr_time;
            end
            if (room) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
            if (wr_last) begin
                frame_done_d = 1'b1;
                feat_cnt_d   = room ? (wr_cnt_q + 1'b1) : CW'(MAX_FEAT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q     <= '0;
            feat_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            feat_cnt_q   <= feat_cnt_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    // Payload storage carries no reset; it is only read once frame_done qualifies it.
    always_ff @(posedge clk) begin
        frame_time_q <= frame_time_d;
        if (wr_fire && room) begin
            rk_mem[wr_cnt_q[IW-1:0]]  <= wr_rk;
            phi_mem[wr_cnt_q[IW-1:0]] <= wr_phi;
        end
    end

    assign rd_rk      = rk_mem[rd_idx[IW-1:0]];
    assign rd_phi     = phi_mem[rd_idx[IW-1:0]];
    assign frame_done = frame_done_q;
    assign feat_cnt   = feat_cnt_q;
    assign frame_time = frame_time_q;
    assign ovf        = ovf_q;
endmodule

// File: rtl/ekf_stage_sequencer.sv
// Command sequencer feeding the EKF Top core: one PRD per odometry sample, then NEW/ASSOC per
// buffered feature when the frame is time-aligned. Optional wait-state watchdog: EKF_SEQ_WDT_EN.
module ekf_stage_sequencer
    import ekf_pkg::*;
#(
    parameter int DW        = 32,
    parameter int TW        = 32,
    parameter int MAX_FEAT  = 20,
    parameter int ASSOC_WIN = 20,
    parameter int PULSE_LEN = 2
`ifdef EKF_SEQ_WDT_EN
    , parameter int WDT_CYCLES = 65535
`endif
) (
    input  logic          clk,
    input  logic          sys_rst_n,
    input  logic          odo_val,
    output logic          odo_rdy,
    input  logic [DW-1:0] odo_vlr,
    input  logic [DW-1:0] odo_alpha,
    input  logic [TW-1:0] odo_time,
    input  logic          obs_val,
    output logic          obs_rdy,
    input  logic [DW-1:0] obs_rk,
    input  logic [DW-1:0] obs_phi,
    input  logic          obs_last,
    input  logic [TW-1:0] obs_time,
    output logic [2:0]    stage_val,
    output logic [DW-1:0] vlr,
    output logic [DW-1:0] alpha,
    output logic [DW-1:0] rk,
    output logic [DW-1:0] phi,
    input  logic          stage_rdy,
    output logic          busy,
    output logic          feat_ovf,
    output logic          wdt_err
);
    localparam int CW = $clog2(MAX_FEAT + 1);
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic signed [TW:0] WIN = (TW+1)'(ASSOC_WIN);

    seq_state_e    state_q, state_d;
    logic          odo_full_q, odo_full_d;
    logic [DW-1:0] odo_vlr_q, odo_vlr_d, odo_alpha_q, odo_alpha_d;
    logic [TW-1:0] odo_time_q, odo_time_d, cur_time_q, cur_time_d;
    logic          init_q, init_d;
    logic [CW-1:0] idx_q, idx_d, idx_next;
    logic [PW-1:0] pulse_q, pulse_d;
    logic [2:0]    stage_q, stage_d;
    logic [DW-1:0] vlr_q, vlr_d, alpha_q, alpha_d, rk_q, rk_d, phi_q, phi_d;
    logic          busy_q, busy_d;
    logic          odo_fire, rel;
    logic [CW-1:0] rd_idx, feat_cnt;
    logic [DW-1:0] rd_rk, rd_phi;
    logic          frame_done;
    logic [TW-1:0] frame_time;
    logic signed [TW:0] diff;

`ifdef EKF_SEQ_WDT_EN
    localparam int WDW = $clog2(WDT_CYCLES + 1);
    logic [WDW-1:0] wdt_cnt_q, wdt_cnt_d;
    logic           wdt_err_q, wdt_err_d;
`endif

    ekf_feat_buf #(.DW(DW), .TW(TW), .MAX_FEAT(MAX_FEAT)) u_feat_buf (
        .clk(clk), .rst_n(sys_rst_n),
        .wr_val(obs_val), .wr_rk(obs_rk), .wr_phi(obs_phi), .wr_last(obs_last),
        .wr_time(obs_time), .wr_rdy(obs_rdy), .rel(rel), .rd_idx(rd_idx),
        .rd_rk(rd_rk), .rd_phi(rd_phi), .frame_done(frame_done), .feat_cnt(feat_cnt),
        .frame_time(frame_time), .ovf(feat_ovf)
    );

    assign odo_fire = odo_val && !odo_full_q;
    assign idx_next = idx_q + 1'b1;
    // Read address is the feature about to be issued, so operands can be registered on entry.
    assign rd_idx   = (state_q == SEQ_FEAT_WAIT) ? idx_next : '0;
    assign diff     = $signed({frame_time[TW-1], frame_time}) - $signed({cur_time_q[TW-1], cur_time_q});

    always_comb begin
        state_d     = state_q;
        odo_full_d  = odo_full_q;
        odo_vlr_d   = odo_vlr_q;
        odo_alpha_d = odo_alpha_q;
        odo_time_d  = odo_time_q;
        cur_time_d  = cur_time_q;
        init_d      = init_q;
        idx_d       = idx_q;
        pulse_d     = pulse_q;
        stage_d     = stage_q;
        vlr_d       = vlr_q;
        alpha_d     = alpha_q;
        rk_d        = rk_q;
        phi_d       = phi_q;
        rel         = 1'b0;
        if (odo_fire) begin
            odo_full_d  = 1'b1;
            odo_vlr_d   = odo_vlr;
            odo_alpha_d = odo_alpha;
            odo_time_d  = odo_time;
        end
        case (state_q)
            SEQ_IDLE: begin
                if (odo_full_q) begin
                    state_d    = SEQ_PRD_ISSUE;
                    odo_full_d = 1'b0;
                    vlr_d      = odo_vlr_q;
                    alpha_d    = odo_alpha_q;
                    cur_time_d = odo_time_q;
                    stage_d    = STAGE_PRD;
                    pulse_d    = '0;
                end
            end
            SEQ_PRD_ISSUE, SEQ_FEAT_ISSUE: begin
                if (pulse_q == PW'(PULSE_LEN - 1)) begin
                    state_d = (state_q == SEQ_PRD_ISSUE) ? SEQ_PRD_WAIT : SEQ_FEAT_WAIT;
                    stage_d = STAGE_IDLE;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            SEQ_PRD_WAIT: begin
                if (stage_rdy) state_d = SEQ_CHECK;
            end
            SEQ_CHECK: begin
                if (frame_done) begin
                    if (diff <= WIN) begin
                        state_d = SEQ_FEAT_ISSUE;
                        idx_d   = '0;
                        rk_d    = rd_rk;
                        phi_d   = rd_phi;
                        stage_d = init_q ? STAGE_NEW : STAGE_ASSOC;
                        pulse_d = '0;
                    end else begin
                        state_d = SEQ_IDLE;
                    end
                end
            end
            SEQ_FEAT_WAIT: begin
                if (stage_rdy) begin
                    idx_d = idx_next;
                    if (idx_next == feat_cnt) begin
                        rel     = 1'b1;
                        init_d  = 1'b0;
                        state_d = SEQ_IDLE;
                    end else begin
                        state_d = SEQ_FEAT_ISSUE;
                        rk_d    = rd_rk;
                        phi_d   = rd_phi;
                        stage_d = init_q ? STAGE_NEW : STAGE_ASSOC;
                        pulse_d = '0;
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
`ifdef EKF_SEQ_WDT_EN
        wdt_err_d = wdt_err_q;
        wdt_cnt_d = '0;
        if ((state_q == SEQ_PRD_WAIT || state_q == SEQ_FEAT_WAIT) && state_d == state_q) begin
            if (wdt_cnt_q == WDW'(WDT_CYCLES - 1)) begin
                wdt_err_d = 1'b1;
                state_d   = SEQ_IDLE;
                rel       = 1'b1;
            end else begin
                wdt_cnt_d = wdt_cnt_q + 1'b1;
            end
        end
`endif
        busy_d = (state_d != SEQ_IDLE);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= SEQ_IDLE;
            odo_full_q <= 1'b0;
            init_q     <= 1'b1;
            idx_q      <= '0;
            pulse_q    <= '0;
            stage_q    <= STAGE_IDLE;
            vlr_q      <= '0;
            alpha_q    <= '0;
            rk_q       <= '0;
            phi_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            odo_full_q <= odo_full_d;
            init_q     <= init_d;
            idx_q      <= idx_d;
            pulse_q    <= pulse_d;
            stage_q    <= stage_d;
            vlr_q      <= vlr_d;
            alpha_q    <= alpha_d;
            rk_q       <= rk_d;
            phi_q      <= phi_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        odo_vlr_q   <= odo_vlr_d;
        odo_alpha_q <= odo_alpha_d;
        odo_time_q  <= odo_time_d;
        cur_time_q  <= cur_time_d;
    end

`ifdef EKF_SEQ_WDT_EN
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wdt_cnt_q <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            wdt_err_q <= wdt_err_d;
        end
    end
    assign wdt_err = wdt_err_q;
`else
    assign wdt_err = 1'b0;
`endif

    assign odo_rdy   = !odo_full_q;
    assign stage_val = stage_q;
    assign vlr       = vlr_q;
    assign alpha     = alpha_q;
    assign rk        = rk_q;
    assign phi       = phi_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_ekf_stage_sequencer.sv
// Directed bench for ekf_stage_sequencer: a behavioural Top responder logs every issued command,
// and each scenario compares the log and status outputs against hand-computed values.
`timescale 1ns/1ps
module tb_ekf_stage_sequencer;
    localparam int DW = 32;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          odo_val = 1'b0, odo_rdy;
    logic [DW-1:0] odo_vlr = '0, odo_alpha = '0;
    logic [TW-1:0] odo_time = '0;
    logic          obs_val = 1'b0, obs_rdy;
    logic [DW-1:0] obs_rk = '0, obs_phi = '0;
    logic          obs_last = 1'b0;
    logic [TW-1:0] obs_time = '0;
    logic [2:0]    stage_val;
    logic [DW-1:0] vlr, alpha, rk, phi;
    logic          stage_rdy = 1'b1;
    logic          busy, feat_ovf, wdt_err;

    always #5 clk = ~clk;

    ekf_stage_sequencer #(
        .DW(DW), .TW(TW), .MAX_FEAT(20), .ASSOC_WIN(20), .PULSE_LEN(2)
`ifdef EKF_SEQ_WDT_EN
        , .WDT_CYCLES(100)
`endif
    ) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .odo_val(odo_val), .odo_rdy(odo_rdy), .odo_vlr(odo_vlr), .odo_alpha(odo_alpha),
        .odo_time(odo_time), .obs_val(obs_val), .obs_rdy(obs_rdy), .obs_rk(obs_rk),
        .obs_phi(obs_phi), .obs_last(obs_last), .obs_time(obs_time), .stage_val(stage_val),
        .vlr(vlr), .alpha(alpha), .rk(rk), .phi(phi), .stage_rdy(stage_rdy), .busy(busy),
        .feat_ovf(feat_ovf), .wdt_err(wdt_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural Top: logs each command at its first pulse cycle, then drives stage_rdy.
    logic [2:0]  log_stg[$];
    logic [31:0] log_a[$];
    logic [31:0] log_b[$];
    int          log_cyc[$];
    logic [2:0]  prev_stg = 3'b000;
    int          rdy_cnt = 0;
    bit          hold_mode = 1'b0;
    bit          never_rdy = 1'b0;

    always @(negedge clk) begin
        if (!sys_rst_n) begin
            prev_stg  = 3'b000;
            rdy_cnt   = 0;
            stage_rdy = 1'b1;
        end else begin
            if (stage_val != 3'b000 && prev_stg == 3'b000) begin
                log_stg.push_back(stage_val);
                log_a.push_back(stage_val == 3'b001 ? vlr : rk);
                log_b.push_back(stage_val == 3'b001 ? alpha : phi);
                log_cyc.push_back(cyc);
                if (!hold_mode) begin
                    stage_rdy = 1'b0;
                    rdy_cnt   = 4;
                end
            end else if (stage_val == 3'b000 && prev_stg != 3'b000 && hold_mode) begin
                stage_rdy = 1'b0;
                rdy_cnt   = 30;
            end else if (rdy_cnt > 0 && !never_rdy) begin
                rdy_cnt--;
                if (rdy_cnt == 0) stage_rdy = 1'b1;
            end
            prev_stg = stage_val;
        end
    end

    task automatic send_frame(input int n, input logic [31:0] t, input logic [31:0] rk0,
                              input logic [31:0] phi0);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            @(negedge clk); #1;
            while (!obs_rdy && w < 2000) begin @(negedge clk); #1; w++; end
            if (!obs_rdy) check("obs_rdy_timeout", obs_rdy, 1);
            obs_val  = 1'b1;
            obs_rk   = rk0 + i;
            obs_phi  = phi0 + i;
            obs_last = (i == n - 1);
            obs_time = t;
            @(posedge clk); #1;
        end
        obs_val  = 1'b0;
        obs_last = 1'b0;
    endtask

    task automatic send_odo(input logic [31:0] v, input logic [31:0] a, input logic [31:0] t,
                            output int hs);
        int w = 0;
        @(negedge clk); #1;
        while (!odo_rdy && w < 2000) begin @(negedge clk); #1; w++; end
        if (!odo_rdy) check("odo_rdy_timeout", odo_rdy, 1);
        odo_val   = 1'b1;
        odo_vlr   = v;
        odo_alpha = a;
        odo_time  = t;
        hs        = cyc;
        @(posedge clk); #1;
        odo_val = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int w = 0;
        while (log_stg.size() < n && w < 3000) begin @(negedge clk); #1; w++; end
        if (log_stg.size() < n) check("wait_log", log_stg.size(), n);
    endtask

    task automatic wait_cmds(input int n);
        int w = 0;
        wait_log(n);
        while (busy && w < 3000) begin @(negedge clk); #1; w++; end
        if (busy) check("wait_idle", busy, 0);
        repeat (10) @(negedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int hs, b, p;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stage_val", stage_val, 0);
        check("rst_vlr", vlr, 0);
        check("rst_alpha", alpha, 0);
        check("rst_rk", rk, 0);
        check("rst_phi", phi, 0);
        check("rst_busy", busy, 0);
        check("rst_feat_ovf", feat_ovf, 0);
        check("rst_wdt_err", wdt_err, 0);
        check("rst_odo_rdy", odo_rdy, 1);
        check("rst_obs_rdy", obs_rdy, 1);
        sys_rst_n = 1'b1;

        // First processed frame: PRD then NEW x3 in buffer order.
        send_frame(3, 10, 1000, 2000);
        send_odo(1048576, 131072, 0, hs);
        wait_log(1);
        check("prd_latency", log_cyc[0] - hs, 2);
        check("odo_freed_at_issue", odo_rdy, 1);
        wait_cmds(4);
        check("t1_count", log_stg.size(), 4);
        check("t1_prd", log_stg[0], 3'b001);
        check("t1_vlr", log_a[0], 1048576);
        check("t1_alpha", log_b[0], 131072);
        for (int i = 0; i < 3; i++) begin
            check("t1_new_stage", log_stg[1+i], 3'b010);
            check("t1_new_rk", log_a[1+i], 1000 + i);
            check("t1_new_phi", log_b[1+i], 2000 + i);
        end

        // Later frame: ASSOC.
        b = log_stg.size();
        send_frame(2, 110, 3000, 4000);
        send_odo(5, 6, 100, hs);
        wait_cmds(b + 3);
        check("t2_count", log_stg.size(), b + 3);
        check("t2_prd_vlr", log_a[b], 5);
        check("t2_assoc0", log_stg[b+1], 3'b100);
        check("t2_assoc0_rk", log_a[b+1], 3000);
        check("t2_assoc1", log_stg[b+2], 3'b100);
        check("t2_assoc1_phi", log_b[b+2], 4001);

        // Frame ahead of the window is kept until an aligned odometry sample; boundary diff=20.
        b = log_stg.size();
        send_frame(2, 50, 5000, 6000);
        send_odo(7, 8, 0, hs);
        wait_cmds(b + 1);
        check("t3_prd_only", log_stg.size(), b + 1);
        check("t3_frame_kept", obs_rdy, 0);
        send_odo(21, 22, 29, hs);
        wait_cmds(b + 2);
        check("t3_diff21_kept", log_stg.size(), b + 2);
        send_odo(9, 10, 30, hs);
        wait_cmds(b + 5);
        check("t3_count", log_stg.size(), b + 5);
        check("t3_prd", log_stg[b+2], 3'b001);
        check("t3_prd_vlr", log_a[b+2], 9);
        check("t3_assoc0", log_stg[b+3], 3'b100);
        check("t3_assoc0_rk", log_a[b+3], 5000);
        check("t3_assoc1_rk", log_a[b+4], 5001);
        check("t3_frame_freed", obs_rdy, 1);

        // Stale frame (negative difference) is processed.
        b = log_stg.size();
        send_frame(1, 5, 7000, 8000);
        send_odo(11, 12, 100, hs);
        wait_cmds(b + 2);
        check("t4_count", log_stg.size(), b + 2);
        check("t4_assoc", log_stg[b+1], 3'b100);
        check("t4_rk", log_a[b+1], 7000);

        // Overflow: 22 features, 20 stored and issued.
        b = log_stg.size();
        check("t5_ovf_before", feat_ovf, 0);
        send_frame(22, 1000, 100, 200);
        check("t5_ovf_set", feat_ovf, 1);
        send_odo(13, 14, 1000, hs);
        wait_cmds(b + 21);
        check("t5_count", log_stg.size(), b + 21);
        check("t5_first_rk", log_a[b+1], 100);
        check("t5_last_rk", log_a[b+20], 119);
        check("t5_last_phi", log_b[b+20], 219);
        check("t5_last_stage", log_stg[b+20], 3'b100);

        // stage_rdy high through the pulse, low for 30 cycles after it.
        hold_mode = 1'b1;
        b = log_stg.size();
        send_frame(1, 2000, 9000, 9500);
        send_odo(15, 16, 2000, hs);
        wait_cmds(b + 2);
        hold_mode = 1'b0;
        check("t6_count", log_stg.size(), b + 2);
        check("t6_gap", log_cyc[b+1] - log_cyc[b], 34);
        check("t6_rk", log_a[b+1], 9000);

        // Asynchronous reset during a feature pulse.
        b = log_stg.size();
        send_frame(2, 3000, 11000, 12000);
        send_odo(17, 18, 3000, hs);
        wait_log(b + 2);
        sys_rst_n = 1'b0;
        #1;
        check("t7_stage_val", stage_val, 0);
        check("t7_busy", busy, 0);
        check("t7_vlr", vlr, 0);
        check("t7_rk", rk, 0);
        check("t7_phi", phi, 0);
        check("t7_odo_rdy", odo_rdy, 1);
        check("t7_obs_rdy", obs_rdy, 1);
        check("t7_feat_ovf", feat_ovf, 0);
        @(negedge clk); #1;
        sys_rst_n = 1'b1;
        b = log_stg.size();
        send_frame(1, 50, 13000, 14000);
        send_odo(19, 20, 50, hs);
        wait_cmds(b + 2);
        check("t7_new_after_reset", log_stg[b+1], 3'b010);
        check("t7_new_rk", log_a[b+1], 13000);

`ifdef EKF_SEQ_WDT_EN
        // Watchdog: Top never completes the prediction.
        never_rdy = 1'b1;
        b = log_stg.size();
        send_frame(1, 60, 15000, 16000);
        send_odo(23, 24, 60, hs);
        wait_log(b + 1);
        p = log_cyc[b];
        repeat (50) @(negedge clk);
        #1;
        check("t8_wdt_early", wdt_err, 0);
        check("t8_busy_waiting", busy, 1);
        begin
            int w = 0;
            while (!wdt_err && w < 300) begin @(negedge clk); #1; w++; end
        end
        check("t8_wdt_set", wdt_err, 1);
        check("t8_wdt_window", (cyc - p >= 95) && (cyc - p <= 110), 1);
        check("t8_busy_cleared", busy, 0);
        check("t8_frame_dropped", obs_rdy, 1);
        never_rdy = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
